// File: rtl/sram_arbiter.sv
// Two-port arbiter for the board SRAM (Ram1): round-robins port A / port B and
// sequences the OE/WE/EN strobes and the tri-state data bus for each access.
module sram_arbiter #(
   parameter int ADDR_W    = 18,
   parameter int DATA_W    = 16,
   parameter int RD_CYCLES = 2,
   parameter int WR_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_done,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_done,
   output logic [ADDR_W-1:0] Ram1Addr,
   inout  wire  [DATA_W-1:0] Ram1Data,
   output logic              Ram1OE,
   output logic              Ram1WE,
   output logic              Ram1EN,
   output logic [2:0]        state_dbg
);

   // Handshake: a requester raises req with we/addr/wdata stable and keeps req
   // high until it sees done=1 for one cycle; the fields are captured at grant
   // and later changes are ignored until the next grant.

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD       = 3'd1,
      S_WR_SETUP = 3'd2,
      S_WR_PULSE = 3'd3,
      S_WR_HOLD  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              last_b, last_b_n;
   logic              grant;
   logic              drive_q;
   logic [DATA_W-1:0] wdata_q;

   assign state_dbg = state;
   assign Ram1Data  = drive_q ? wdata_q : {DATA_W{1'bz}};

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      last_b_n = last_b;
      grant    = 1'b0;
      case (state)
         S_IDLE: begin
            if (a_req || b_req) begin
               grant    = 1'b1;
               // Under contention the port that did not win last time goes next.
               last_b_n = (a_req && b_req) ? ~last_b : b_req;
               state_n  = (last_b_n ? b_we : a_we) ? S_WR_SETUP : S_RD;
               cnt_n    = CW'(RD_CYCLES - 1);
            end
         end
         S_RD: begin
            if (cnt == '0) state_n = S_DONE;
            else           cnt_n   = cnt - 1'b1;
         end
         S_WR_SETUP: begin
            state_n = S_WR_PULSE;
            cnt_n   = CW'(WR_CYCLES - 1);
         end
         S_WR_PULSE: begin
            if (cnt == '0) state_n = S_WR_HOLD;
            else           cnt_n   = cnt - 1'b1;
         end
         S_WR_HOLD: state_n = S_DONE;
         S_DONE:    state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= S_IDLE;
         cnt    <= '0;
         last_b <= 1'b1;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         last_b <= last_b_n;
      end
   end

   // Pin strobes are decoded from the next state so they change on the same
   // edge as the state register and never glitch.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Ram1Addr <= '0;
         wdata_q  <= '0;
         drive_q  <= 1'b0;
         Ram1EN   <= 1'b1;
         Ram1OE   <= 1'b1;
         Ram1WE   <= 1'b1;
         a_done   <= 1'b0;
         b_done   <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         if (grant) begin
            Ram1Addr <= last_b_n ? b_addr  : a_addr;
            wdata_q  <= last_b_n ? b_wdata : a_wdata;
         end
         drive_q <= (state_n inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
         Ram1EN  <= !(state_n inside {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
         Ram1OE  <= (state_n != S_RD);
         Ram1WE  <= (state_n != S_WR_PULSE);
         a_done  <= (state_n == S_DONE) && !last_b;
         b_done  <= (state_n == S_DONE) &&  last_b;
         if (state == S_RD && cnt == '0) begin
            if (last_b) b_rdata <= Ram1Data;
            else        a_rdata <= Ram1Data;
         end
      end
   end

endmodule
